// File: rtl/bram_burst_pkg.sv
// Shared types and defaults for the BRAM burst initiator.
package bram_burst_pkg;

    localparam int unsigned N_DEFAULT     = 15;
    localparam int unsigned LEN_W_DEFAULT = 16;
    localparam int unsigned RD_FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        DONE
    } state_t;

endpackage

// File: rtl/bram_burst_master_rd_skid_fifo.sv
// Two-entry read return buffer; covers the BRAM read latency under backpressure.
module rd_skid_fifo (
    input  logic        CLK,
    input  logic        RST,
    input  logic        push,
    input  logic [31:0] push_data,
    input  logic        pop,
    output logic [31:0] head,
    output logic [1:0]  count
);

    logic [31:0] mem [2];
    logic        rptr;
    logic        wptr;
    logic        pop_ok;
    logic        push_ok;

    assign pop_ok  = pop && (count != 2'd0);
    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign push_ok = push && ((count != 2'd2) || pop_ok);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rptr   <= 1'b0;
            wptr   <= 1'b0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wptr] <= push_data;
                wptr      <= ~wptr;
            end
            if (pop_ok) begin
                rptr <= ~rptr;
            end
            count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

    assign head = mem[rptr];

endmodule

// File: rtl/bram_burst_master.sv
// Burst initiator for the single-port user-project BRAM: one command becomes
// a run of consecutive word accesses, with stream-side write and read beats.
module bram_burst_master
    import bram_burst_pkg::*;
#(
    parameter int unsigned N     = N_DEFAULT,
    parameter int unsigned LEN_W = LEN_W_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [31:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [31:0]      wr_data,
    input  logic [3:0]       wr_strb,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [31:0]      rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic             done,
    output logic             busy,
    output logic             bram_EN0,
    output logic [3:0]       bram_WE0,
    output logic [31:0]      bram_Di0,
    output logic [31:0]      bram_A0,
    input  logic [31:0]      bram_Do0
);

    state_t           state;
    state_t           state_nxt;
    logic [31:0]      addr;
    logic [31:0]      addr_inc;
    logic [LEN_W-1:0] issue_left;
    logic [LEN_W-1:0] ret_left;
    logic             inflight;
    logic [1:0]       fifo_count;
    logic [31:0]      fifo_head;
    logic             beat_wr;
    logic             rd_issue;
    logic             rd_pop;
    logic [2:0]       credit;

    // Word index and page bits step separately so the carry out of the BRAM
    // index is explicit; together they form an ordinary 32-bit wrap-around +1.
    assign addr_inc = {addr[31:N] + (32-N)'(&addr[N-1:0]), addr[N-1:0] + 1'b1};

    assign rd_valid = (fifo_count != 2'd0);
    assign rd_data  = fifo_head;
    assign rd_pop   = rd_valid && rd_ready;
    assign busy     = (state != IDLE);
    // Words held or in flight after this cycle's hand-off must stay within the buffer.
    assign credit   = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, rd_pop};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        done      = 1'b0;
        bram_EN0  = 1'b0;
        bram_WE0  = '0;
        bram_Di0  = '0;
        bram_A0   = addr;
        beat_wr   = 1'b0;
        rd_issue  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_len == '0) begin
                        state_nxt = DONE;
                    end else if (cmd_write) begin
                        state_nxt = WRITE;
                    end else begin
                        state_nxt = READ;
                    end
                end
            end
            WRITE: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    beat_wr  = 1'b1;
                    bram_EN0 = 1'b1;
                    bram_WE0 = wr_strb;
                    bram_Di0 = wr_data;
                    if (ret_left == LEN_W'(1)) begin
                        state_nxt = DONE;
                    end
                end
            end
            READ: begin
                if ((issue_left != '0) && (credit < 3'(RD_FIFO_DEPTH))) begin
                    rd_issue = 1'b1;
                    bram_EN0 = 1'b1;
                end
                if (rd_pop && (ret_left == LEN_W'(1))) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            addr       <= '0;
            issue_left <= '0;
            ret_left   <= '0;
            inflight   <= 1'b0;
        end else begin
            inflight <= rd_issue;
            if ((state == IDLE) && cmd_valid) begin
                addr       <= cmd_addr;
                issue_left <= cmd_len;
                ret_left   <= cmd_len;
            end
            if (beat_wr || rd_issue) begin
                addr <= addr_inc;
            end
            if (rd_issue) begin
                issue_left <= issue_left - 1'b1;
            end
            if (beat_wr || rd_pop) begin
                ret_left <= ret_left - 1'b1;
            end
        end
    end

    rd_skid_fifo u_rd_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (inflight),
        .push_data (bram_Do0),
        .pop       (rd_pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_bram_burst_master.sv
// Randomised bench for bram_burst_master with a behavioural BRAM and a reference memory image.
module tb_bram_burst_master;

    localparam int unsigned AW    = 15;
    localparam int unsigned DEPTH = 1 << AW;

    logic        CLK = 1'b0;
    logic        RST;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_len;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic        done;
    logic        busy;
    logic        bram_EN0;
    logic [3:0]  bram_WE0;
    logic [31:0] bram_Di0;
    logic [31:0] bram_A0;
    logic [31:0] bram_Do0 = '0;

    always #5 CLK = ~CLK;

    bram_burst_master #(.N(15), .LEN_W(16)) dut (
        .CLK(CLK), .RST(RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .done(done), .busy(busy),
        .bram_EN0(bram_EN0), .bram_WE0(bram_WE0), .bram_Di0(bram_Di0),
        .bram_A0(bram_A0), .bram_Do0(bram_Do0)
    );

    logic [31:0] bram_mem [DEPTH];
    logic [31:0] ref_mem  [DEPTH];

    // Behavioural BRAM: one-cycle read latency, zero output when not enabled.
    always @(posedge CLK) begin
        if (bram_EN0) begin
            for (int b = 0; b < 4; b++)
                if (bram_WE0[b]) bram_mem[bram_A0[AW-1:0]][b*8 +: 8] <= bram_Di0[b*8 +: 8];
            bram_Do0 <= bram_mem[bram_A0[AW-1:0]];
        end else begin
            bram_Do0 <= '0;
        end
    end

    int checks    = 0;
    int failures  = 0;
    int done_seen = 0;
    int done_exp  = 0;

    always @(negedge CLK) if (done) done_seen++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    logic [31:0] wdq [$];
    logic [3:0]  wsq [$];
    logic [31:0] rd_log [$];

    task automatic send_cmd(input bit wr, input logic [31:0] a, input int unsigned len);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_len   = 16'(len);
        #1;
        check("cmd_ready_idle", 32'(cmd_ready), 1);
        check("cmd_no_access", 32'(bram_EN0), 0);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic finish_burst(input string tag);
        #1;
        check({tag, "_done"}, 32'(done), 1);
        check({tag, "_done_busy"}, 32'(busy), 1);
        check({tag, "_done_noen"}, 32'(bram_EN0), 0);
        tick();
        #1;
        check({tag, "_done_clear"}, 32'(done), 0);
        check({tag, "_ready_back"}, 32'(cmd_ready), 1);
        done_exp++;
    endtask

    task automatic run_write(input logic [31:0] a, input int unsigned len, input bit gaps);
        int unsigned i = 0;
        int unsigned budget = 0;
        bit acc;
        logic [31:0] wa;
        send_cmd(1'b1, a, len);
        while (i < len && budget < 1000) begin
            wr_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            wr_data  = wdq[i];
            wr_strb  = wsq[i];
            #1;
            acc = 1'b0;
            if (wr_valid) begin
                check("wr_en", 32'(bram_EN0), 1);
                check("wr_we", 32'(bram_WE0), 32'(wsq[i]));
                check("wr_addr", bram_A0, a + i);
                check("wr_di", bram_Di0, wdq[i]);
                acc = wr_ready;
            end else begin
                check("wr_gap_en", {27'd0, bram_EN0, bram_WE0}, 0);
            end
            tick();
            if (acc) begin
                wa = a + i;
                for (int b = 0; b < 4; b++)
                    if (wsq[i][b]) ref_mem[wa[AW-1:0]][b*8 +: 8] = wdq[i][b*8 +: 8];
                i++;
            end
            budget++;
        end
        wr_valid = 1'b0;
        if (budget >= 1000) check("wr_timeout", i, len);
        finish_burst("wr");
    endtask

    // mode 0: always ready, 1: ready toggles 1010..., 2: random ready
    task automatic run_read(input logic [31:0] a, input int unsigned len, input int mode);
        int unsigned issued = 0;
        int unsigned got = 0;
        int cyc = 0;
        int first = -1;
        int last = 0;
        bit pop;
        logic [31:0] ra;
        rd_log = {};
        send_cmd(1'b0, a, len);
        while (got < len && cyc < 2000) begin
            case (mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = (cyc % 2 == 0);
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            pop = rd_valid && rd_ready;
            if (bram_EN0) begin
                check("rd_we", 32'(bram_WE0), 0);
                check("rd_addr", bram_A0, a + issued);
                check("rd_credit", 32'((issued - got - 32'(pop)) < 2), 1);
                check("rd_overissue", 32'(issued < len), 1);
                issued++;
            end
            if (pop) begin
                ra = a + got;
                check("rd_data", rd_data, ref_mem[ra[AW-1:0]]);
                rd_log.push_back(rd_data);
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            tick();
            cyc++;
        end
        rd_ready = 1'b0;
        if (cyc >= 2000) check("rd_timeout", got, len);
        if (mode == 0) check("rd_back_to_back", 32'(last - first), len - 1);
        check("rd_fifo_drained", 32'(rd_valid), 0);
        finish_burst("rd");
    endtask

    task automatic load_random(input int unsigned len, input bit rnd_strb);
        wdq = {};
        wsq = {};
        for (int unsigned k = 0; k < len; k++) begin
            wdq.push_back($urandom);
            wsq.push_back(rnd_strb ? 4'($urandom_range(0, 15)) : 4'hF);
        end
    endtask

    initial begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
            bram_mem[k] = '0;
            ref_mem[k]  = '0;
        end
        RST = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_data = '0; wr_strb = '0; wr_valid = 1'b0; rd_ready = 1'b0;
        tick(); tick();
        check("rst_cmd_ready", 32'(cmd_ready), 1);
        check("rst_wr_ready", 32'(wr_ready), 0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_done", 32'(done), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_en_we", {27'd0, bram_EN0, bram_WE0}, 0);
        check("rst_di", bram_Di0, 0);
        check("rst_a", bram_A0, 0);
        RST = 1'b0;
        tick();

        // 4 words at 0x10, then back-to-back read
        wdq = {32'hA0, 32'hA1, 32'hA2, 32'hA3};
        wsq = {4'hF, 4'hF, 4'hF, 4'hF};
        run_write(32'h10, 4, 1'b0);
        run_read(32'h10, 4, 0);
        check("basic_last_word", rd_log[3], 32'hA3);

        // 8 words with toggling backpressure
        load_random(8, 1'b0);
        run_write(32'h20, 8, 1'b1);
        run_read(32'h20, 8, 1);
        check("toggle_count", rd_log.size(), 8);

        // Partial strobe merge
        wdq = {32'h11223344}; wsq = {4'hF};
        run_write(32'h40, 1, 1'b0);
        wdq = {32'hFFFFFFFF}; wsq = {4'h2};
        run_write(32'h40, 1, 1'b0);
        run_read(32'h40, 1, 0);
        check("strb_merge", rd_log[0], 32'h1122FF44);

        // Wrap across the top of the BRAM
        wdq = {32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002};
        wsq = {4'hF, 4'hF, 4'hF};
        run_write(32'h7FFF, 3, 1'b0);
        run_read(32'h7FFF, 3, 2);
        check("wrap_low_word", rd_log[1], 32'hC0DE0001);

        // Zero-length no-op
        send_cmd(1'b1, 32'h55, 0);
        finish_burst("zero");

        // Reset with two words buffered and no consumer
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h10; cmd_len = 16'd6;
        tick();
        cmd_valid = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        check("pre_rst_rd_valid", 32'(rd_valid), 1);
        check("pre_rst_no_issue", 32'(bram_EN0), 0);
        RST = 1'b1;
        #1;
        check("mid_rst_rd_valid", 32'(rd_valid), 0);
        check("mid_rst_en", 32'(bram_EN0), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_rd_data", rd_data, 0);
        tick();
        RST = 1'b0;
        tick();
        run_read(32'h10, 4, 0);
        check("post_rst_first", rd_log[0], 32'hA0);

        // Randomised bursts, some straddling the wrap point
        for (int t = 0; t < 8; t++) begin
            int unsigned len;
            logic [31:0] a;
            len = $urandom_range(1, 10);
            a = (t % 3 == 0) ? 32'($urandom_range(DEPTH - 6, DEPTH - 1)) + ($urandom & 32'hFFFF8000)
                             : $urandom;
            load_random(len, 1'b1);
            run_write(a, len, 1'b1);
            run_read(a, len, 2);
        end

        check("done_pulses", done_seen, done_exp);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
